// File: rtl/dest_pipe_fwd_if.sv
// dest_pipe_fwd_if: ID-side inputs (dest/regwrite/memread/valid/rs/rt/uses_rt, hold, flush) and hazard/forward/writeback outputs
interface dest_pipe_fwd_if #(parameter int CNT_W = 16);
  logic [4:0] id_dest;
  logic id_regwrite;
  logic id_memread;
  logic id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic id_uses_rt;
  logic hold;
  logic flush;
  logic stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [4:0] wb_dest;
  logic wb_regwrite;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output id_dest, id_regwrite, id_memread, id_valid, id_rs, id_rt, id_uses_rt, hold, flush,
    input stall, fwd_a, fwd_b, wb_dest, wb_regwrite, stall_count
  );
  modport slave (
    input id_dest, id_regwrite, id_memread, id_valid, id_rs, id_rt, id_uses_rt, hold, flush,
    output stall, fwd_a, fwd_b, wb_dest, wb_regwrite, stall_count
  );
endinterface

// File: rtl/dest_pipe_fwd.sv
// dest_pipe_fwd: tracks ID dest reg through EX/MEM/WB; ports clk, rst_n, bus (slave) giving stall, fwd_a/fwd_b, wb_dest/wb_regwrite, stall_count
module dest_pipe_fwd #(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  dest_pipe_fwd_if.slave bus
);
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic [4:0] dest;
  } wr_t;
  typedef struct packed {
    wr_t w;
    logic memread;
    logic [4:0] rs;
    logic [4:0] rt;
  } ex_t;
  ex_t ex_q, ex_d;
  wr_t mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic lu, stall_c;
  function automatic logic [1:0] fwd_sel(input wr_t m, input wr_t w, input logic [4:0] x);
    return (m.valid & m.regwrite & (|m.dest) & (m.dest == x)) ? 2'b10 :
           (w.valid & w.regwrite & (|w.dest) & (w.dest == x)) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    lu = bus.id_valid & ex_q.w.valid & ex_q.memread & (|ex_q.w.dest) &
         ((ex_q.w.dest == bus.id_rs) | (bus.id_uses_rt & (ex_q.w.dest == bus.id_rt)));
    stall_c = lu & ~bus.flush;
    ex_d = bus.hold ? ex_q : (bus.flush | lu) ? '0 :
           {bus.id_valid, bus.id_regwrite & bus.id_valid, bus.id_dest,
            bus.id_memread & bus.id_valid, bus.id_rs, bus.id_rt};
    mem_d = bus.hold ? mem_q : ex_q.w;
    wb_d = bus.hold ? wb_q : mem_q;
    cnt_d = (stall_c & ~bus.hold & ~(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
      cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      mem_q <= mem_d;
      wb_q <= wb_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.stall = stall_c;
  assign bus.fwd_a = ex_q.w.valid ? fwd_sel(mem_q, wb_q, ex_q.rs) : 2'b00;
  assign bus.fwd_b = ex_q.w.valid ? fwd_sel(mem_q, wb_q, ex_q.rt) : 2'b00;
  assign bus.wb_dest = wb_q.dest;
  assign bus.wb_regwrite = wb_q.valid & wb_q.regwrite;
  assign bus.stall_count = cnt_q;
endmodule

// File: tb/tb_dest_pipe_fwd.sv
// tb_dest_pipe_fwd: directed stimulus with a writeback scoreboard for dest_pipe_fwd
module tb_dest_pipe_fwd;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  dest_pipe_fwd_if #(.CNT_W(CW)) bus ();
  dest_pipe_fwd #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic v;
    logic rw;
    logic mr;
    logic [4:0] d;
    logic [4:0] rs;
    logic [4:0] rt;
    logic ut;
  } ins_t;
  typedef struct {
    logic [4:0] d;
    int n;
  } sb_t;
  sb_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  bit skip_fwd = 0;
  function automatic ins_t op(input logic [4:0] d, input logic [4:0] rs, input logic [4:0] rt);
    return '{v: 1'b1, rw: 1'b1, mr: 1'b0, d: d, rs: rs, rt: rt, ut: 1'b1};
  endfunction
  function automatic ins_t ld(input logic [4:0] d, input logic [4:0] rs);
    return '{v: 1'b1, rw: 1'b1, mr: 1'b1, d: d, rs: rs, rt: 5'd0, ut: 1'b0};
  endfunction
  function automatic ins_t nop();
    return '0;
  endfunction
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input ins_t i, input logic fl, input logic hd,
                      input logic es, input logic [1:0] ea, input logic [1:0] eb);
    logic exp_wr;
    bus.id_valid = i.v;
    bus.id_regwrite = i.rw;
    bus.id_memread = i.mr;
    bus.id_dest = i.d;
    bus.id_rs = i.rs;
    bus.id_rt = i.rt;
    bus.id_uses_rt = i.ut;
    bus.flush = fl;
    bus.hold = hd;
    @(negedge clk);
    chk({tag, ".stall"}, 16'(bus.stall), 16'(es));
    if (!skip_fwd) begin
      chk({tag, ".fwd_a"}, 16'(bus.fwd_a), 16'(ea));
      chk({tag, ".fwd_b"}, 16'(bus.fwd_b), 16'(eb));
    end
    exp_wr = (sb.size() > 0) && (sb[0].n == 0);
    chk({tag, ".wb_we"}, 16'(bus.wb_regwrite), 16'(exp_wr));
    if (exp_wr) chk({tag, ".wb_dest"}, 16'(bus.wb_dest), 16'(sb[0].d));
    chk({tag, ".cnt"}, 16'(bus.stall_count), 16'(exp_cnt));
    @(posedge clk);
    if (!hd) begin
      if (sb.size() > 0 && sb[0].n == 0) void'(sb.pop_front());
      foreach (sb[k]) sb[k].n--;
      if (i.v && i.rw && !fl && !es) sb.push_back('{d: i.d, n: 2});
      if (es && exp_cnt < (1 << CW) - 1) exp_cnt++;
    end
    #1;
  endtask
  task automatic drain(input int n);
    skip_fwd = 1;
    for (int k = 0; k < n; k++) step("drain", nop(), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    skip_fwd = 0;
  endtask
  initial begin
    bus.id_valid = 0;
    bus.id_regwrite = 0;
    bus.id_memread = 0;
    bus.id_dest = 0;
    bus.id_rs = 0;
    bus.id_rt = 0;
    bus.id_uses_rt = 0;
    bus.flush = 0;
    bus.hold = 0;
    #2;
    chk("rst.stall", 16'(bus.stall), 16'd0);
    chk("rst.fwd_a", 16'(bus.fwd_a), 16'd0);
    chk("rst.fwd_b", 16'(bus.fwd_b), 16'd0);
    chk("rst.wb_dest", 16'(bus.wb_dest), 16'd0);
    chk("rst.wb_we", 16'(bus.wb_regwrite), 16'd0);
    chk("rst.cnt", 16'(bus.stall_count), 16'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst2.wb_we", 16'(bus.wb_regwrite), 16'd0);
    #1 rst_n = 1'b1;
    step("fill0", op(9, 1, 2), 0, 0, 0, 2'b00, 2'b00);
    step("fill1", nop(), 0, 0, 0, 2'b00, 2'b00);
    step("fill2", nop(), 0, 0, 0, 2'b00, 2'b00);
    step("fill3", nop(), 0, 0, 0, 2'b00, 2'b00);
    step("fill4", nop(), 0, 0, 0, 2'b00, 2'b00);
    drain(3);
    step("b2b0", op(8, 1, 2), 0, 0, 0, 2'b00, 2'b00);
    step("b2b1", op(10, 8, 8), 0, 0, 0, 2'b00, 2'b00);
    step("b2b2", nop(), 0, 0, 0, 2'b10, 2'b10);
    drain(3);
    step("gap0", op(8, 1, 2), 0, 0, 0, 2'b00, 2'b00);
    step("gap1", op(11, 3, 4), 0, 0, 0, 2'b00, 2'b00);
    step("gap2", op(12, 8, 8), 0, 0, 0, 2'b00, 2'b00);
    step("gap3", nop(), 0, 0, 0, 2'b01, 2'b01);
    drain(3);
    step("dbl0", op(5, 1, 2), 0, 0, 0, 2'b00, 2'b00);
    step("dbl1", op(5, 1, 2), 0, 0, 0, 2'b00, 2'b00);
    step("dbl2", op(13, 5, 6), 0, 0, 0, 2'b00, 2'b00);
    step("dbl3", nop(), 0, 0, 0, 2'b10, 2'b00);
    step("r0_0", op(0, 1, 2), 0, 0, 0, 2'b00, 2'b00);
    step("r0_1", op(0, 1, 2), 0, 0, 0, 2'b00, 2'b00);
    step("r0_2", op(14, 0, 0), 0, 0, 0, 2'b00, 2'b00);
    step("r0_3", nop(), 0, 0, 0, 2'b00, 2'b00);
    drain(3);
    step("lu0", ld(3, 1), 0, 0, 0, 2'b00, 2'b00);
    step("lu1", op(15, 1, 3), 0, 0, 1, 2'b00, 2'b00);
    step("lu2", op(15, 1, 3), 0, 0, 0, 2'b00, 2'b00);
    step("lu3", nop(), 0, 0, 0, 2'b00, 2'b01);
    step("nut0", ld(3, 1), 0, 0, 0, 2'b00, 2'b00);
    step("nut1", '{v: 1'b1, rw: 1'b1, mr: 1'b0, d: 5'd19, rs: 5'd1, rt: 5'd3, ut: 1'b0}, 0, 0, 0, 2'b00, 2'b00);
    step("nut2", nop(), 0, 0, 0, 2'b00, 2'b10);
    drain(3);
    step("fl0", ld(3, 1), 0, 0, 0, 2'b00, 2'b00);
    step("fl1", op(16, 3, 2), 1, 0, 0, 2'b00, 2'b00);
    step("fl2", nop(), 0, 0, 0, 2'b00, 2'b00);
    drain(3);
    step("hd0", ld(4, 1), 0, 0, 0, 2'b00, 2'b00);
    for (int k = 0; k < 4; k++) step("hdh", op(17, 4, 2), 0, 1, 1, 2'b00, 2'b00);
    step("hd1", op(17, 4, 2), 0, 0, 1, 2'b00, 2'b00);
    step("hd2", op(17, 4, 2), 0, 0, 0, 2'b00, 2'b00);
    step("hd3", nop(), 0, 0, 0, 2'b01, 2'b00);
    drain(3);
    skip_fwd = 1;
    for (int k = 0; k < 20; k++) begin
      step("satL", ld(6, 1), 0, 0, 0, 2'b00, 2'b00);
      step("satS", op(18, 6, 2), 0, 0, 1, 2'b00, 2'b00);
      step("satO", op(18, 6, 2), 0, 0, 0, 2'b00, 2'b00);
    end
    skip_fwd = 0;
    drain(3);
    chk("sat", 16'(bus.stall_count), 16'd15);
    step("mr0", op(20, 1, 2), 0, 0, 0, 2'b00, 2'b00);
    step("mr1", op(21, 1, 2), 0, 0, 0, 2'b00, 2'b00);
    step("mr2", op(22, 1, 2), 0, 0, 0, 2'b00, 2'b00);
    bus.id_valid = 0;
    #2;
    chk("mr.pre_we", 16'(bus.wb_regwrite), 16'd1);
    chk("mr.pre_fwd_a", 16'(bus.fwd_a), 16'd0);
    rst_n = 1'b0;
    #1;
    chk("mr.we", 16'(bus.wb_regwrite), 16'd0);
    chk("mr.dest", 16'(bus.wb_dest), 16'd0);
    chk("mr.cnt", 16'(bus.stall_count), 16'd0);
    sb.delete();
    exp_cnt = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    drain(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
